// File: rtl/ctrl_responder.sv
// ctrl_responder: request/response register slave with a three-state FSM.
// A request strobe in IDLE captures its type, address and data. After a fixed
// number of wait cycles the block responds with a one-cycle acknowledge.
//
// Register map:
//   0 CFG (RW)
//   1 DATA (RW)
//   2 SCRATCH (RW)
//   3 STATUS (RO), a count of completed transactions
//
// Ports:
//   clk     - sole clock, rising edge
//   rst     - asynchronous active-high reset
//   start_s - single-cycle request strobe
//   we_s    - request type: 1 write, 0 read
//   addr_s  - register address
//   data_s  - write data
//   ack_c   - single-cycle completion strobe
//   rdata_c - read data, nonzero only on a read acknowledge
//   err_c   - error flag, set on a write to the read-only STATUS register
//   ovr_c   - sticky overrun flag, set by a start_s while busy
//   cfg_c   - continuous copy of CFG
module ctrl_responder #(
  parameter logic [3:0] WIDTH   = 4'd8,
  parameter int         LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_s,
  input  logic             we_s,
  input  logic [1:0]       addr_s,
  input  logic [WIDTH-1:0] data_s,
  output logic             ack_c,
  output logic [WIDTH-1:0] rdata_c,
  output logic             err_c,
  output logic             ovr_c,
  output logic [WIDTH-1:0] cfg_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // WAIT lasts LATENCY cycles, so the counter is loaded with LATENCY-1
  localparam logic [3:0]       WAIT_LOAD = 4'(LATENCY - 1);
  localparam logic [WIDTH-1:0] STAT_ONE  = {{(WIDTH - 1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_wait_cnt;
  logic             r_we;
  logic [1:0]       r_addr;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_cfg;
  logic [WIDTH-1:0] r_dat;
  logic [WIDTH-1:0] r_scr;
  logic [WIDTH-1:0] r_status;
  logic             r_ack;
  logic             r_err;
  logic             r_ovr;
  logic [WIDTH-1:0] r_rdata;

  logic             w_enter_resp;
  logic             w_we_eff;
  logic [1:0]       w_addr_eff;
  logic [WIDTH-1:0] w_data_eff;
  logic [WIDTH-1:0] w_rd_mux;
  logic             w_ack_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_rdata_nxt;

  // With zero latency, RESP is entered on the capture edge itself. The
  // holding registers are still empty at that point, so use the live inputs
  // while in IDLE.
  assign w_we_eff     = (r_state == S_IDLE) ? we_s   : r_we;
  assign w_addr_eff   = (r_state == S_IDLE) ? addr_s : r_addr;
  assign w_data_eff   = (r_state == S_IDLE) ? data_s : r_data;
  assign w_enter_resp = (w_state_nxt == S_RESP);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_s) begin
          w_state_nxt = (LATENCY > 0) ? S_WAIT : S_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read mux; STATUS still holds its pre-increment value at the entry edge
  always_comb begin
    w_rd_mux = '0;
    case (w_addr_eff)
      2'd0:    w_rd_mux = r_cfg;
      2'd1:    w_rd_mux = r_dat;
      2'd2:    w_rd_mux = r_scr;
      2'd3:    w_rd_mux = r_status;
      default: w_rd_mux = '0;
    endcase
  end

  // FSM output logic: response values that are registered on entry to RESP
  always_comb begin
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;
    if (w_enter_resp) begin
      w_ack_nxt = 1'b1;
      if (w_we_eff) begin
        w_err_nxt   = (w_addr_eff == 2'd3);
        w_rdata_nxt = '0;
      end else begin
        w_err_nxt   = 1'b0;
        w_rdata_nxt = w_rd_mux;
      end
    end else begin
      w_ack_nxt = 1'b0;
    end
  end

  // Request holding registers and the wait-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= 2'd0;
      r_data     <= '0;
      r_wait_cnt <= 4'd0;
    end else begin
      if (r_state == S_IDLE && start_s) begin
        r_we       <= we_s;
        r_addr     <= addr_s;
        r_data     <= data_s;
        r_wait_cnt <= WAIT_LOAD;
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // Register file writes (on RESP entry) and the STATUS count (on RESP exit)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg    <= '0;
      r_dat    <= '0;
      r_scr    <= '0;
      r_status <= '0;
    end else begin
      if (w_enter_resp && w_we_eff) begin
        case (w_addr_eff)
          2'd0:    r_cfg <= w_data_eff;
          2'd1:    r_dat <= w_data_eff;
          2'd2:    r_scr <= w_data_eff;
          default: ;  // STATUS is read-only
        endcase
      end
      if (r_state == S_RESP) begin
        r_status <= r_status + STAT_ONE;
      end
    end
  end

  // Registered response outputs and the sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      if (start_s && r_state != S_IDLE) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign ack_c   = r_ack;
  assign err_c   = r_err;
  assign rdata_c = r_rdata;
  assign ovr_c   = r_ovr;
  assign cfg_c   = r_cfg;

endmodule

// File: tb/tb_ctrl_responder.sv
// Directed bench for ctrl_responder.
// Instance A uses LATENCY=2 and instance B uses LATENCY=0. For each request,
// the expected response is pushed to a scoreboard queue when the request is
// driven, and popped when ack_c is seen.
module tb_ctrl_responder;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic       a_start, a_we, b_start, b_we;
  logic [1:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ack, a_err, a_ovr, b_ack, b_err, b_ovr;
  logic [7:0] a_rdata, a_cfg, b_rdata, b_cfg;
  logic [7:0] cfg_at_ack;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  ctrl_responder #(.WIDTH(4'd8), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst_a), .start_s(a_start), .we_s(a_we), .addr_s(a_addr),
    .data_s(a_data), .ack_c(a_ack), .rdata_c(a_rdata), .err_c(a_err),
    .ovr_c(a_ovr), .cfg_c(a_cfg)
  );

  ctrl_responder #(.WIDTH(4'd8), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst_b), .start_s(b_start), .we_s(b_we), .addr_s(b_addr),
    .data_s(b_data), .ack_c(b_ack), .rdata_c(b_rdata), .err_c(b_err),
    .ovr_c(b_ovr), .cfg_c(b_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic we,
                       input logic [1:0] ad, input logic [7:0] d);
    if (sel) begin
      b_start = st; b_we = we; b_addr = ad; b_data = d;
    end else begin
      a_start = st; a_we = we; a_addr = ad; a_data = d;
    end
  endtask

  function automatic logic ack_of(input bit sel);
    return sel ? b_ack : a_ack;
  endfunction

  // One transaction, called at a falling edge. The inputs are inverted after
  // capture to show that the holding registers are used. If dbl is set,
  // start stays high for a second cycle, which should be an overrun.
  task automatic txn(input bit sel, input logic we, input logic [1:0] ad,
                     input logic [7:0] d, input bit dbl,
                     input logic [7:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   t0;
    int   lat;
    bit   seen;
    lat     = sel ? 1 : 3;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    drive(sel, 1'b1, we, ad, d);
    t0   = cyc;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      drive(sel, (k == 0) ? dbl : 1'b0, ~we, ~ad, ~d);
      if (ack_of(sel)) begin
        seen       = 1'b1;
        cfg_at_ack = sel ? b_cfg : a_cfg;
        chk("ack_latency", cyc - t0, lat);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rdata", sel ? b_rdata : a_rdata, e.rdata);
          chk("err", sel ? b_err : a_err, e.err);
        end else begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end
      end
    end
    if (!seen) begin
      chk("ack_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
    end else begin
      @(negedge clk);
      chk("ack_single_cycle", ack_of(sel), 1'b0);
      chk("rdata_idle_zero", sel ? b_rdata : a_rdata, 8'h00);
    end
    drive(sel, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", a_ack, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_rdata", a_rdata, 8'h00);
    chk("rst_ovr", a_ovr, 1'b0);
    chk("rst_cfg", a_cfg, 8'h00);
    rst_a = 1'b0;
  endtask

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("init_a_ack", a_ack, 1'b0);
    chk("init_a_err", a_err, 1'b0);
    chk("init_a_rdata", a_rdata, 8'h00);
    chk("init_a_ovr", a_ovr, 1'b0);
    chk("init_a_cfg", a_cfg, 8'h00);
    chk("init_b_ack", b_ack, 1'b0);
    chk("init_b_cfg", b_cfg, 8'h00);
    rst_a = 1'b0; rst_b = 1'b0;

    // Write then read. The first start is on the edge right after reset.
    txn(1'b0, 1'b1, 2'd1, 8'hA5, 1'b0, 8'h00, 1'b0);
    txn(1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 8'hA5, 1'b0);
    txn(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h02, 1'b0);

    // CFG mirror and STATUS count
    reset_a();
    txn(1'b0, 1'b1, 2'd0, 8'h3C, 1'b0, 8'h00, 1'b0);
    chk("cfg_at_ack", cfg_at_ack, 8'h3C);
    chk("cfg_hold", a_cfg, 8'h3C);
    txn(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h01, 1'b0);
    txn(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h3C, 1'b0);

    // Write to the read-only STATUS register
    reset_a();
    txn(1'b0, 1'b1, 2'd3, 8'hFF, 1'b0, 8'h00, 1'b1);
    txn(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h01, 1'b0);
    chk("ro_cfg_untouched", a_cfg, 8'h00);

    // Overrun: a second start one cycle after an accepted start
    reset_a();
    txn(1'b0, 1'b1, 2'd2, 8'h5A, 1'b0, 8'h00, 1'b0);
    chk("ovr_clear_before", a_ovr, 1'b0);
    txn(1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 8'h5A, 1'b0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack) n++;
    end
    chk("ovr_no_extra_ack", n, 0);
    chk("ovr_set", a_ovr, 1'b1);
    txn(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h02, 1'b0);
    chk("ovr_sticky", a_ovr, 1'b1);
    reset_a();

    // Reset asserted in WAIT aborts a write
    drive(1'b0, 1'b1, 1'b1, 2'd2, 8'h77);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    rst_a = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_ack) n++;
    end
    chk("abort_no_ack", n, 0);
    rst_a = 1'b0;
    txn(1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0);

    // Zero latency: 256 STATUS reads, then check the wrap to zero
    for (int i = 0; i < 256; i++) begin
      txn(1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'(i), 1'b0);
    end
    txn(1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("b_no_overrun", b_ovr, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_responder.md
CTRL_RESPONDER -- requirements
Module: ctrl_responder

Interface
REQ-001 The block SHALL have parameter WIDTH, type logic [3:0], default 8, giving the data width of every data port and register.
REQ-002 The block SHALL have parameter LATENCY, type int, default 2, giving the number of wait cycles between request capture and response (legal range 0..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-004 Port: clk, input, 1, sole clock, all logic on rising edge.
REQ-005 Port: rst, input, 1, asynchronous active-high reset.
REQ-006 Port: start_s, input, 1, single-cycle request strobe from the initiator.
REQ-007 Port: we_s, input, 1, request type, 1 = write, 0 = read, qualified by start_s.
REQ-008 Port: addr_s, input, 2, register address, qualified by start_s.
REQ-009 Port: data_s, input, WIDTH, write data, qualified by start_s.
REQ-010 Port: ack_c, output, 1, single-cycle completion strobe.
REQ-011 Port: rdata_c, output, WIDTH, read data, valid while ack_c=1 on a read.
REQ-012 Port: err_c, output, 1, error flag, valid only while ack_c=1.
REQ-013 Port: ovr_c, output, 1, sticky overrun flag.
REQ-014 Port: cfg_c, output, WIDTH, continuous copy of register 0.

Function
REQ-015 Register map SHALL be: 0 CFG (RW), 1 DATA (RW), 2 SCRATCH (RW), 3 STATUS (RO, completed-transaction count).
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 FSM transitions SHALL be: IDLE->WAIT on start_s when LATENCY>0; IDLE->RESP on start_s when LATENCY=0; WAIT->RESP after LATENCY cycles; RESP->IDLE unconditionally.
REQ-018 On start_s in IDLE, the block SHALL capture we_s, addr_s and data_s into internal holding registers; later changes on those inputs SHALL have no effect on the transaction.
REQ-019 Latency SHALL be exactly LATENCY+1 cycles from the start_s cycle to the ack_c cycle.
REQ-020 ack_c SHALL be high for exactly one cycle, in RESP only.
REQ-021 A write to address 0..2 SHALL update the target register at the edge that enters RESP, so the new value is visible while ack_c=1; err_c SHALL be 0 for it.
REQ-022 A write to address 3 SHALL leave all registers unchanged and SHALL assert err_c with ack_c.
REQ-023 A read SHALL drive the captured register's value on rdata_c with ack_c; err_c SHALL be 0.
REQ-024 On a write acknowledge, and whenever ack_c=0, rdata_c SHALL be 0.
REQ-025 STATUS SHALL increment by 1 at every RESP cycle, including error writes, and SHALL wrap from 2^WIDTH-1 to 0.
REQ-026 A read of STATUS SHALL return the count before the current transaction's increment.
REQ-027 start_s asserted in WAIT or RESP SHALL be ignored (not queued) and SHALL set ovr_c to 1.
REQ-028 Once set, ovr_c SHALL stay at 1 until reset.
REQ-029 start_s in the same cycle as RESP SHALL be ignored; a new request is accepted only when the FSM is in IDLE.

Reset
REQ-030 While rst=1, the block SHALL asynchronously force FSM=IDLE, all registers and the STATUS counter to 0, and ack_c, err_c, ovr_c, rdata_c and cfg_c to 0.
REQ-031 Reset asserted mid-transaction SHALL abort that transaction with no ack_c, and no write SHALL take effect.
REQ-032 The first start_s SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=8, LATENCY=2 unless stated)
REQ-033 Write then read: write 0xA5 to addr 1, then read addr 1 -> ack_c 3 cycles after each start_s; read returns rdata_c=0xA5 with err_c=0.
REQ-034 Config and status: write 0x3C to addr 0 -> cfg_c=0x3C from the ack cycle; a following read of addr 3 returns 0x01.
REQ-035 RO violation: write 0xFF to addr 3 -> ack_c with err_c=1; a subsequent read of addr 3 returns 0x01, unchanged by the write.
REQ-036 Overrun: start_s one cycle after an accepted start_s -> only one ack_c is produced and ovr_c=1 persists until rst.
REQ-037 Wrap and zero latency: with LATENCY=0, run 256 reads -> ack_c one cycle after each start_s; STATUS wraps to 0x00.
REQ-038 Mid-transaction reset: assert rst in WAIT during a write of 0x77 to addr 2 -> no ack_c; a read of addr 2 returns 0x00.
